irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have a parameter N_CH, default 4, giving the number of interrupt source channels (legal range 2..16).
REQ-002 The block SHALL have a parameter CAUSE_W, default 2, giving the cause width, equal to ceil(log2(N_CH)).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 irq_src  input  N_CH  level interrupt lines; the block latches each rising edge.
REQ-007 pc31  input  1  kernel-mode flag; when 1, no new interrupt is offered.
REQ-008 take  input  1  one-cycle pulse: the pipeline has accepted the offered interrupt.
REQ-009 eret  input  1  one-cycle pulse: the handler has returned.
REQ-010 mask_we  input  1  mask write strobe.
REQ-011 mask_wdata  input  N_CH  new mask value; bit=1 enables that channel.
REQ-012 irq_out  output  1  registered interrupt request to the control decoder.
REQ-013 cause  output  CAUSE_W  index of the offered or in-service channel.
REQ-014 pending  output  N_CH  latched, not-yet-taken edges.
REQ-015 mask  output  N_CH  current mask register.

Function
REQ-016 The block SHALL set pending[i] at a clock edge where irq_src[i]=1 and the registered previous value of irq_src[i] is 0.
REQ-017 Eligible channels are pending & mask; the block SHALL select the lowest eligible index (fixed priority).
REQ-018 FSM states: IDLE, REQ, SERVICE. irq_out SHALL be 1 only in REQ.
REQ-019 IDLE->REQ: at the next edge when any channel is eligible and pc31=0; cause SHALL be loaded with the selected index at that edge.
REQ-020 In REQ, cause SHALL be held stable even if a higher-priority channel becomes eligible.
REQ-021 REQ->SERVICE: on take=1; pending[cause] SHALL be cleared at the same edge.
REQ-022 REQ->IDLE (withdraw): if take=0 and either pc31=1 or channel cause is no longer eligible; the pending bit SHALL be kept.
REQ-023 SERVICE->IDLE: on eret=1; cause SHALL hold its value until the next REQ entry.
REQ-024 In SERVICE, take SHALL be ignored and no nesting is permitted; eret outside SERVICE SHALL be ignored.
REQ-025 If a new rising edge on channel i coincides with the clear of pending[i], set SHALL win.
REQ-026 A mask write SHALL take effect at the write edge; eligibility SHALL use the new mask from the following cycle.
REQ-027 Latency (no sync): irq_src rising before edge k -> pending set at k -> irq_out=1 after edge k+1.

Reset
REQ-028 On reset=1 at an edge: state=IDLE, irq_out=0, cause=0, pending=0, mask=all ones, and the edge-detect and synchroniser registers SHALL be set to 0; reset SHALL override all other inputs, including mid-REQ or mid-SERVICE.

Configuration
REQ-029 The macro IRQ_CTRL_SYNC_EN, when defined, SHALL insert a two-flop synchroniser on each irq_src bit ahead of edge detection, adding 2 cycles to REQ-027's latency; when undefined, irq_src SHALL feed edge detection directly.

Structure
REQ-030 The shared package irq_ctrl_pkg SHALL hold the FSM state encoding (IDLE=2'b00, REQ=2'b01, SERVICE=2'b10) and the N_CH/CAUSE_W defaults.
REQ-031 The lowest-index priority encoder SHALL be a sub-module irq_prio_enc (inputs req[N_CH]; outputs idx[CAUSE_W], valid).

Verification
REQ-032 Scenario: reset, then raise irq_src=4'b0100 with pc31=0 -> pending=4'b0100 after 1 edge; irq_out=1 and cause=2 after 2 edges; take pulse -> pending=0, state=SERVICE; eret -> IDLE.
REQ-033 Scenario: raise irq_src=4'b1010 in one cycle -> cause=1; after take and eret -> cause=3 is offered next.
REQ-034 Scenario: in REQ with cause=2, drive pc31=1 -> irq_out=0 next edge and pending[2] stays 1; drive pc31=0 -> irq_out=1 again with cause=2.
REQ-035 Scenario: mask_we=1, mask_wdata=4'b1110, then edge on channel 0 -> pending[0]=1 and irq_out stays 0; write mask 4'b1111 -> irq_out=1 with cause=0 two edges later.
REQ-036 Scenario: re-edge on channel 1 in the same cycle as take for cause=1 -> pending[1]=1 after the edge; assert reset in SERVICE -> all outputs at reset values, mask=4'b1111.
REQ-037 Scenario: with IRQ_CTRL_SYNC_EN defined, repeat REQ-032 -> irq_out=1 four edges after the source rises.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared definitions for the interrupt controller:
//   - default channel count and cause width
//   - FSM state encoding (IDLE / REQ / SERVICE)
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

  localparam int N_CH_DEF    = 4;
  localparam int CAUSE_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_e;

endpackage : irq_ctrl_pkg

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Fixed-priority encoder: reports the lowest set index of req.
// Ports:
//   req   [N_CH]    request vector
//   idx   [CAUSE_W] index of the lowest set bit (0 when none set)
//   valid           at least one bit of req is set
// -----------------------------------------------------------------------------
module irq_prio_enc #(
  parameter int N_CH    = 4,
  parameter int CAUSE_W = 2
) (
  input  logic [N_CH-1:0]    req,
  output logic [CAUSE_W-1:0] idx,
  output logic               valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    idx   = '0;
    valid = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = CAUSE_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule : irq_prio_enc

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Edge-latching interrupt controller with a per-channel mask, fixed-priority
// selection and a three-state request/service handshake with the pipeline.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   irq_src     [N_CH]    level interrupt lines, rising edges are latched
//   pc31                  kernel-mode flag, blocks / withdraws the offer
//   take                  pipeline accepted the offered interrupt (pulse)
//   eret                  handler returned (pulse)
//   mask_we               mask write strobe
//   mask_wdata  [N_CH]    new mask value, 1 = channel enabled
//   irq_out               registered interrupt request (1 only in REQ)
//   cause       [CAUSE_W] offered / in-service channel index
//   pending     [N_CH]    latched, not-yet-taken edges
//   mask        [N_CH]    current mask register
//
// Build option:
//   IRQ_CTRL_SYNC_EN  when defined, a two-flop synchroniser sits on each
//                     irq_src bit ahead of edge detection (+2 cycles latency).
// -----------------------------------------------------------------------------
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int CAUSE_W = CAUSE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_CH-1:0]    irq_src,
  input  logic               pc31,
  input  logic               take,
  input  logic               eret,
  input  logic               mask_we,
  input  logic [N_CH-1:0]    mask_wdata,
  output logic               irq_out,
  output logic [CAUSE_W-1:0] cause,
  output logic [N_CH-1:0]    pending,
  output logic [N_CH-1:0]    mask
);

  state_e              state_q,   state_d;
  logic [CAUSE_W-1:0]  cause_q,   cause_d;
  logic [N_CH-1:0]     pending_q, pending_d;
  logic [N_CH-1:0]     mask_q,    mask_d;
  logic                irq_out_q, irq_out_d;

  logic [N_CH-1:0]     src_det;
  logic [N_CH-1:0]     prev_q;
  logic [N_CH-1:0]     rise;
  logic [N_CH-1:0]     eligible;
  logic [N_CH-1:0]     clr;
  logic [CAUSE_W-1:0]  sel_idx;
  logic                sel_valid;

  // ---------------------------------------------------------------------------
  // Optional input synchroniser
  // ---------------------------------------------------------------------------
`ifdef IRQ_CTRL_SYNC_EN
  logic [N_CH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_det = sync2_q;
`else
  assign src_det = irq_src;
`endif

  // ---------------------------------------------------------------------------
  // Edge detection and selection
  // ---------------------------------------------------------------------------
  assign rise     = src_det & ~prev_q;
  assign eligible = pending_q & mask_q;

  irq_prio_enc #(
    .N_CH    (N_CH),
    .CAUSE_W (CAUSE_W)
  ) u_prio_enc (
    .req   (eligible),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    clr     = '0;

    case (state_q)
      IDLE: begin
        if (sel_valid && !pc31) begin
          state_d = REQ;
          cause_d = sel_idx;
        end
      end
      REQ: begin
        // cause is frozen here; a newly eligible higher-priority channel waits.
        if (take) begin
          state_d      = SERVICE;
          clr[cause_q] = 1'b1;
        end else if (pc31 || !eligible[cause_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge on the channel being cleared must survive: set wins.
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = mask_we ? mask_wdata : mask_q;
    irq_out_d = (state_d == REQ);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      irq_out_q <= 1'b0;
      prev_q    <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_out_q <= irq_out_d;
      prev_q    <= src_det;
    end
  end

  assign irq_out = irq_out_q;
  assign cause   = cause_q;
  assign pending = pending_q;
  assign mask    = mask_q;

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
// Directed testbench for irq_ctrl (N_CH=4). Works with or without
// IRQ_CTRL_SYNC_EN; the synchroniser adds SYNC_LAT cycles ahead of the
// pending register. Inputs change 1 time unit after each rising edge and
// outputs are sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src;
  logic       pc31;
  logic       take;
  logic       eret;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       irq_out;
  logic [1:0] cause;
  logic [3:0] pending;
  logic [3:0] mask;

  int vectors     = 0;
  int miscompares = 0;

  irq_ctrl #(.N_CH(4), .CAUSE_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .pc31       (pc31),
    .take       (take),
    .eret       (eret),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_out    (irq_out),
    .cause      (cause),
    .pending    (pending),
    .mask       (mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the edge-detect pipeline see the current (low) irq_src level.
  task automatic flush();
    repeat (SYNC_LAT + 1) tick();
  endtask

  task automatic pulse_take();
    take = 1'b1; tick(); take = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic test_reset();
    irq_src = 4'b0000; pc31 = 1'b0; take = 1'b0; eret = 1'b0;
    mask_we = 1'b1; mask_wdata = 4'b0000;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; mask_we = 1'b0;
    vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL reset_irq_out: got %b expected 0", irq_out); end
    vectors++; if (cause !== 2'd0) begin miscompares++; $display("FAIL reset_cause: got %0d expected 0", cause); end
    vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL reset_pending: got %b expected 0000", pending); end
    vectors++; if (mask !== 4'b1111) begin miscompares++; $display("FAIL reset_mask: got %b expected 1111", mask); end
    vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_basic();
    irq_src = 4'b0100;
    repeat (SYNC_LAT) tick();
    tick();
    vectors++; if (pending !== 4'b0100) begin miscompares++; $display("FAIL basic_pending: got %b expected 0100", pending); end
    vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL basic_irq_early: got %b expected 0", irq_out); end
    tick();
    vectors++; if (irq_out !== 1'b1) begin miscompares++; $display("FAIL basic_irq_out: got %b expected 1", irq_out); end
    vectors++; if (cause !== 2'd2) begin miscompares++; $display("FAIL basic_cause: got %0d expected 2", cause); end
    pulse_take();
    vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL basic_take_pending: got %b expected 0000", pending); end
    vectors++; if (dut.state_q !== SERVICE) begin miscompares++; $display("FAIL basic_take_state: got %0d expected %0d", dut.state_q, SERVICE); end
    vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL basic_svc_irq: got %b expected 0", irq_out); end
    pulse_take();
    vectors++; if (dut.state_q !== SERVICE) begin miscompares++; $display("FAIL basic_take_in_svc: got %0d expected %0d", dut.state_q, SERVICE); end
    pulse_eret();
    vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL basic_eret_state: got %0d expected %0d", dut.state_q, IDLE); end
    pulse_eret();
    vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL basic_eret_idle: got %0d expected %0d", dut.state_q, IDLE); end
    irq_src = 4'b0000;
    flush();
  endtask

  task automatic test_priority();
    irq_src = 4'b1010;
    flush();
    vectors++; if (pending !== 4'b1010) begin miscompares++; $display("FAIL prio_pending: got %b expected 1010", pending); end
    tick();
    vectors++; if (irq_out !== 1'b1 || cause !== 2'd1) begin miscompares++; $display("FAIL prio_first: got irq=%b cause=%0d expected irq=1 cause=1", irq_out, cause); end
    pulse_take();
    vectors++; if (pending !== 4'b1000) begin miscompares++; $display("FAIL prio_take_pending: got %b expected 1000", pending); end
    pulse_eret();
    vectors++; if (irq_out !== 1'b0 || cause !== 2'd1) begin miscompares++; $display("FAIL prio_cause_hold: got irq=%b cause=%0d expected irq=0 cause=1", irq_out, cause); end
    tick();
    vectors++; if (irq_out !== 1'b1 || cause !== 2'd3) begin miscompares++; $display("FAIL prio_second: got irq=%b cause=%0d expected irq=1 cause=3", irq_out, cause); end
    // Higher-priority channel 0 arrives while REQ holds cause 3.
    irq_src = 4'b1011;
    flush();
    vectors++; if (pending !== 4'b1001 || cause !== 2'd3 || irq_out !== 1'b1) begin miscompares++; $display("FAIL prio_req_stable: got pend=%b cause=%0d irq=%b expected pend=1001 cause=3 irq=1", pending, cause, irq_out); end
    pulse_take();
    vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL prio_take3_pending: got %b expected 0001", pending); end
    pulse_eret();
    tick();
    vectors++; if (irq_out !== 1'b1 || cause !== 2'd0) begin miscompares++; $display("FAIL prio_third: got irq=%b cause=%0d expected irq=1 cause=0", irq_out, cause); end
    pulse_take();
    pulse_eret();
    irq_src = 4'b0000;
    flush();
  endtask

  task automatic test_withdraw();
    irq_src = 4'b0100;
    flush();
    tick();
    vectors++; if (irq_out !== 1'b1 || cause !== 2'd2) begin miscompares++; $display("FAIL wd_offer: got irq=%b cause=%0d expected irq=1 cause=2", irq_out, cause); end
    pc31 = 1'b1;
    tick();
    vectors++; if (irq_out !== 1'b0 || pending !== 4'b0100) begin miscompares++; $display("FAIL wd_pc31: got irq=%b pend=%b expected irq=0 pend=0100", irq_out, pending); end
    tick();
    vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL wd_pc31_block: got %b expected 0", irq_out); end
    pc31 = 1'b0;
    tick();
    vectors++; if (irq_out !== 1'b1 || cause !== 2'd2) begin miscompares++; $display("FAIL wd_reoffer: got irq=%b cause=%0d expected irq=1 cause=2", irq_out, cause); end
    // Masking the offered channel withdraws it one cycle after the write.
    mask_we = 1'b1; mask_wdata = 4'b1011;
    tick();
    mask_we = 1'b0;
    vectors++; if (irq_out !== 1'b1 || mask !== 4'b1011) begin miscompares++; $display("FAIL wd_mask_edge: got irq=%b mask=%b expected irq=1 mask=1011", irq_out, mask); end
    tick();
    vectors++; if (irq_out !== 1'b0 || pending !== 4'b0100) begin miscompares++; $display("FAIL wd_masked: got irq=%b pend=%b expected irq=0 pend=0100", irq_out, pending); end
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    tick();
    vectors++; if (irq_out !== 1'b1 || cause !== 2'd2) begin miscompares++; $display("FAIL wd_unmask: got irq=%b cause=%0d expected irq=1 cause=2", irq_out, cause); end
    pulse_take();
    pulse_eret();
    irq_src = 4'b0000;
    flush();
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_wdata = 4'b1110;
    tick();
    mask_we = 1'b0;
    irq_src = 4'b0001;
    flush();
    vectors++; if (pending !== 4'b0001 || irq_out !== 1'b0) begin miscompares++; $display("FAIL mask_pending: got pend=%b irq=%b expected pend=0001 irq=0", pending, irq_out); end
    tick();
    vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL mask_blocked: got %b expected 0", irq_out); end
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL mask_write_edge: got %b expected 0", irq_out); end
    tick();
    vectors++; if (irq_out !== 1'b1 || cause !== 2'd0) begin miscompares++; $display("FAIL mask_enable: got irq=%b cause=%0d expected irq=1 cause=0", irq_out, cause); end
    pulse_take();
    pulse_eret();
    irq_src = 4'b0000;
    flush();
  endtask

  task automatic test_set_wins();
    irq_src = 4'b0010;
    flush();
    tick();
    vectors++; if (irq_out !== 1'b1 || cause !== 2'd1) begin miscompares++; $display("FAIL sw_offer: got irq=%b cause=%0d expected irq=1 cause=1", irq_out, cause); end
    irq_src = 4'b0000;
    flush();
    irq_src = 4'b0010;
    repeat (SYNC_LAT) tick();
    pulse_take();
    vectors++; if (pending !== 4'b0010 || dut.state_q !== SERVICE) begin miscompares++; $display("FAIL sw_set_wins: got pend=%b state=%0d expected pend=0010 state=%0d", pending, dut.state_q, SERVICE); end
    // Reset in SERVICE with every other input active.
    reset = 1'b1; take = 1'b1; eret = 1'b1; pc31 = 1'b1;
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    reset = 1'b0; take = 1'b0; eret = 1'b0; pc31 = 1'b0; mask_we = 1'b0;
    irq_src = 4'b0000;
    vectors++; if (irq_out !== 1'b0 || cause !== 2'd0 || pending !== 4'b0000 || mask !== 4'b1111) begin miscompares++; $display("FAIL sw_reset_outputs: got irq=%b cause=%0d pend=%b mask=%b expected 0 0 0000 1111", irq_out, cause, pending, mask); end
    vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL sw_reset_state: got %0d expected %0d", dut.state_q, IDLE); end
    tick();
    vectors++; if (irq_out !== 1'b0 || pending !== 4'b0000) begin miscompares++; $display("FAIL sw_post_reset: got irq=%b pend=%b expected irq=0 pend=0000", irq_out, pending); end
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; pc31 = 1'b0; take = 1'b0; eret = 1'b0;
    mask_we = 1'b0; mask_wdata = '0;
    test_reset();
    test_basic();
    test_priority();
    test_withdraw();
    test_mask();
    test_set_wins();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_irq_ctrl
